// File: rtl/periph_pkg.sv
// Shared address-map constants for the memory-mapped switch and LED ports.
package periph_pkg;

    // Register offsets inside the switch port's 16-byte window
    localparam logic [3:0] SW_DATA_OFS  = 4'h0;
    localparam logic [3:0] SW_EVENT_OFS = 4'h4;
    localparam logic [3:0] SW_MASK_OFS  = 4'h8;
    localparam logic [3:0] SW_RAW_OFS   = 4'hC;

    // Byte offset of a word slot; the byte-lane bits are dropped by the caller
    function automatic logic [3:0] word_ofs(input logic [1:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit switch conditioner: two-flop synchroniser followed by a
// stability counter. A new level is accepted only after it has been seen
// at the synchroniser output for DEBOUNCE_CYCLES consecutive clocks.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sw,
    output logic o_sync,
    output logic o_stable,
    output logic o_toggle
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_q1;
    logic             r_q2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_accept;

    assign w_diff   = (r_q2 != r_stable);
    assign w_accept = w_diff && (r_cnt == CNT_LAST);

    // Bring the asynchronous switch level into the clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q1 <= 1'b0;
            r_q2 <= 1'b0;
        end else begin
            r_q1 <= i_sw;
            r_q2 <= r_q1;
        end
    end

    // Count consecutive clocks of disagreement; any agreement restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!w_diff) begin
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_stable <= r_q2;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_sync   = r_q2;
    assign o_stable = r_stable;
    // High in the cycle before stable flips, so the event flag sets on the same edge
    assign o_toggle = w_accept;

endmodule

// File: rtl/switch_input_port.sv
// Memory-mapped switch input port: debounced level, raw synchronised level,
// sticky write-1-to-clear change events and a maskable interrupt.
module switch_input_port
    import periph_pkg::*;
#(
    parameter int          N_SW            = 10,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] BASE_ADDR       = 32'hC000_0010
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] switches,
    input  logic            MemWrite,
    input  logic [31:0]     Address,
    input  logic [31:0]     WriteData,
    output logic [31:0]     ReadData,
    output logic            irq
);

    logic [N_SW-1:0] w_sync;
    logic [N_SW-1:0] w_stable;
    logic [N_SW-1:0] w_toggle;
    logic [N_SW-1:0] r_event;
    logic [N_SW-1:0] r_mask;
    logic [N_SW-1:0] w_clr;
    logic            w_hit;
    logic [3:0]      w_ofs;
    logic            w_wr_event;
    logic            w_wr_mask;
    logic            w_unused;

    for (genvar i = 0; i < N_SW; i++) begin : g_db
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .i_sw    (switches[i]),
            .o_sync  (w_sync[i]),
            .o_stable(w_stable[i]),
            .o_toggle(w_toggle[i])
        );
    end

    assign w_hit      = (Address[31:4] == BASE_ADDR[31:4]);
    assign w_ofs      = word_ofs(Address[3:2]);
    assign w_wr_event = MemWrite && w_hit && (w_ofs == SW_EVENT_OFS);
    assign w_wr_mask  = MemWrite && w_hit && (w_ofs == SW_MASK_OFS);
    assign w_clr      = w_wr_event ? WriteData[N_SW-1:0] : '0;

    // Byte-lane bits and write data above N_SW carry no meaning here
    assign w_unused   = ^{Address[1:0], WriteData};

    // Sticky change flags; a new toggle overrides a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_event <= '0;
        end else begin
            r_event <= (r_event & ~w_clr) | w_toggle;
        end
    end

    // Interrupt enable register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
        end else if (w_wr_mask) begin
            r_mask <= WriteData[N_SW-1:0];
        end
    end

    // Zero-latency read mux; misses read as zero
    always_comb begin
        ReadData = '0;
        if (w_hit) begin
            case (w_ofs)
                SW_DATA_OFS:  ReadData = 32'(w_stable);
                SW_EVENT_OFS: ReadData = 32'(r_event);
                SW_MASK_OFS:  ReadData = 32'(r_mask);
                SW_RAW_OFS:   ReadData = 32'(w_sync);
                default:      ReadData = '0;
            endcase
        end
    end

    assign irq = |(r_event & r_mask);

endmodule

// File: tb/tb_switch_input_port.sv
// Bench for switch_input_port with a 4-clock debounce window.
module tb_switch_input_port;

    logic        clk;
    logic        reset;
    logic [9:0]  switches;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] A_DATA  = 32'hC000_0010;
    localparam logic [31:0] A_EVENT = 32'hC000_0014;
    localparam logic [31:0] A_MASK  = 32'hC000_0018;
    localparam logic [31:0] A_RAW   = 32'hC000_001C;

    switch_input_port #(
        .N_SW           (10),
        .DEBOUNCE_CYCLES(4),
        .BASE_ADDR      (32'hC000_0010)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .switches (switches),
        .MemWrite (MemWrite),
        .Address  (Address),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        Address  = addr;
        MemWrite = 1'b0;
        #1;
        data = ReadData;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        step();
        MemWrite  = 1'b0;
        WriteData = '0;
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        logic [31:0] addrs [4];
        addrs = '{A_DATA, A_EVENT, A_MASK, A_RAW};
        reset = 1'b0;
        switches = 10'h3FF;
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            rd(addrs[i], got);
            exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL reset_read_%0d got=%h exp=%h", i, got, exp); end
        end
        exp_q.push_back(32'h0);
        got = {31'b0, irq};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_irq got=%h exp=%h", got, exp); end

        reset = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h3FF);
        exp_q.push_back(32'h3FF);
        exp_q.push_back(32'h0);
        repeat (5) step();
        rd(A_DATA, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_data_edge5 got=%h exp=%h", got, exp); end
        step();
        rd(A_DATA, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_data_edge6 got=%h exp=%h", got, exp); end
        rd(A_EVENT, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_event_edge6 got=%h exp=%h", got, exp); end
        got = {31'b0, irq};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_irq_unmasked got=%h exp=%h", got, exp); end

        wr(A_EVENT, 32'h3FF);
        exp_q.push_back(32'h0);
        rd(A_EVENT, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_event_clear got=%h exp=%h", got, exp); end

        switches = 10'h000;
        exp_q.push_back(32'h0);
        repeat (7) step();
        rd(A_DATA, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL settle_low_data got=%h exp=%h", got, exp); end
        wr(A_EVENT, 32'h3FF);
    endtask

    task automatic test_latency();
        logic [31:0] got, exp;
        switches = 10'd4;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h4);
        step();
        rd(A_RAW, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL lat_raw_e got=%h exp=%h", got, exp); end
        step();
        rd(A_RAW, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL lat_raw_e1 got=%h exp=%h", got, exp); end
        repeat (3) step();
        rd(A_DATA, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL lat_data_e4 got=%h exp=%h", got, exp); end
        step();
        rd(A_DATA, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL lat_data_e5 got=%h exp=%h", got, exp); end
        rd(A_EVENT, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL lat_event_e5 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_glitch();
        logic [31:0] got, exp;
        wr(A_MASK, 32'h001);
        switches = 10'd5;
        repeat (3) step();
        switches = 10'd4;
        for (int c = 0; c < 10; c++) begin
            step();
            exp_q.push_back(32'h4);
            exp_q.push_back(32'h4);
            exp_q.push_back(32'h0);
            rd(A_DATA, got);
            exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL glitch_data_c%0d got=%h exp=%h", c, got, exp); end
            rd(A_EVENT, got);
            exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL glitch_event_c%0d got=%h exp=%h", c, got, exp); end
            got = {31'b0, irq};
            exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL glitch_irq_c%0d got=%h exp=%h", c, got, exp); end
        end
    endtask

    task automatic test_w1c_irq();
        logic [31:0] got, exp;
        wr(A_MASK, 32'h004);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h1);
        rd(A_MASK, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL w1c_mask got=%h exp=%h", got, exp); end
        got = {31'b0, irq};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL w1c_irq_set got=%h exp=%h", got, exp); end

        wr(A_EVENT, 32'h000);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h1);
        rd(A_EVENT, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL w1c_zero_event got=%h exp=%h", got, exp); end
        got = {31'b0, irq};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL w1c_zero_irq got=%h exp=%h", got, exp); end

        wr(A_EVENT, 32'h004);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        rd(A_EVENT, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL w1c_clear_event got=%h exp=%h", got, exp); end
        got = {31'b0, irq};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL w1c_clear_irq got=%h exp=%h", got, exp); end
    endtask

    task automatic test_collision();
        logic [31:0] got, exp;
        switches = 10'd0;
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        repeat (5) step();
        rd(A_DATA, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL coll_data_before got=%h exp=%h", got, exp); end
        wr(A_EVENT, 32'h004);
        rd(A_EVENT, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL coll_event got=%h exp=%h", got, exp); end
        rd(A_DATA, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL coll_data_after got=%h exp=%h", got, exp); end
        got = {31'b0, irq};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL coll_irq got=%h exp=%h", got, exp); end
    endtask

    task automatic test_decode();
        logic [31:0] got, exp;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        rd(32'hC000_0020, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL dec_miss_above got=%h exp=%h", got, exp); end
        rd(32'hC000_000C, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL dec_miss_below got=%h exp=%h", got, exp); end

        wr(A_DATA, 32'h3FF);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h0);
        rd(A_DATA, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL dec_data_ro got=%h exp=%h", got, exp); end
        rd(32'hC000_0012, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL dec_data_lane got=%h exp=%h", got, exp); end
        rd(32'hC000_0016, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL dec_event_lane got=%h exp=%h", got, exp); end
        rd(32'hC000_001F, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL dec_raw_lane got=%h exp=%h", got, exp); end

        wr(32'hC000_0028, 32'h000);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h1);
        rd(32'hC000_001A, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL dec_miss_write_mask got=%h exp=%h", got, exp); end
        got = {31'b0, irq};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL dec_miss_write_irq got=%h exp=%h", got, exp); end
    endtask

    initial begin
        reset     = 1'b0;
        switches  = '0;
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
        #1;
        test_reset();
        test_latency();
        test_glitch();
        test_w1c_irq();
        test_collision();
        test_decode();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
